operand_entry: RTL and testbench

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry.sv | 98 +++++++++
 tb/tb_operand_entry.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - decimal keypad operand accumulator with one-cycle commit pulse
module operand_entry #(
  parameter int width      = 8,
  parameter int max_digits = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [3:0]       digit_i,
  input  logic             digit_valid_i,
  input  logic             enter_i,
  input  logic             clear_i,
  output logic [width-1:0] operand_o,
  output logic             we_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int cw = $clog2(max_digits + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

  state_t           state, state_n;
  logic [width-1:0] acc, acc_n, operand_n;
  logic [cw-1:0]    count, count_n;
  logic             we_n, overflow_n;
  logic             digit_ok, fits;
  logic [width+3:0] acc_ext, candidate;

  // Codes 10-15 are not digits at all; they never reach the accumulator or the flag.
  assign digit_ok  = digit_valid_i && (digit_i <= 4'd9);
  assign acc_ext   = {4'b0, acc};
  assign candidate = (acc_ext << 3) + (acc_ext << 1) + {{width{1'b0}}, digit_i};
  assign fits      = (candidate <= {4'b0, {width{1'b1}}}) && (count < cw'(max_digits));
  assign busy_o    = (state != IDLE);

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    count_n    = count;
    operand_n  = operand_o;
    we_n       = 1'b0;
    overflow_n = overflow_o;
    case (state)
      IDLE: begin
        if (!clear_i && !enter_i && digit_ok) begin
          state_n = ENTRY;
          acc_n   = width'(digit_i);
          count_n = cw'(1);
        end
      end
      ENTRY: begin
        if (clear_i) begin
          state_n    = IDLE;
          acc_n      = '0;
          count_n    = '0;
          overflow_n = 1'b0;
        end else if (enter_i) begin
          state_n   = COMMIT;
          operand_n = acc;
          we_n      = 1'b1;
        end else if (digit_ok) begin
          if (fits) begin
            acc_n   = candidate[width-1:0];
            count_n = count + cw'(1);
          end else begin
            overflow_n = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_n    = IDLE;
        acc_n      = '0;
        count_n    = '0;
        overflow_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      operand_o  <= '0;
      we_o       <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      count      <= count_n;
      operand_o  <= operand_n;
      we_o       <= we_n;
      overflow_o <= overflow_n;
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - randomized and directed bench for operand_entry against a digit-queue model
module tb_operand_entry;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] digit_i = 4'd0;
  logic       digit_valid_i = 1'b0;
  logic       enter_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] operand_o;
  logic       we_o, overflow_o, busy_o;

  int checks = 0;
  int errors = 0;

  // Model: accepted digits kept as a list; the operand value is evaluated from it.
  int m_mode = 0;  // 0 waiting for a first digit, 1 collecting, 2 commit cycle
  int m_digits[$];
  int m_op = 0;
  bit m_we = 0;
  bit m_ovf = 0;

  operand_entry #(.width(8), .max_digits(3)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .digit_i(digit_i),
    .digit_valid_i(digit_valid_i), .enter_i(enter_i), .clear_i(clear_i),
    .operand_o(operand_o), .we_o(we_o), .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic int digits_value(input int extra, input bit use_extra);
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    if (use_extra) v = v * 10 + extra;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input int d, input bit dv, input bit en, input bit clr);
    bit is_digit = dv && (d <= 9);
    if (rst) begin
      m_mode = 0; m_digits.delete(); m_op = 0; m_we = 0; m_ovf = 0;
      return;
    end
    m_we = 0;
    if (m_mode == 2) begin
      m_mode = 0; m_digits.delete(); m_ovf = 0;
    end else if (m_mode == 0) begin
      if (!clr && !en && is_digit) begin
        m_digits.push_back(d);
        m_mode = 1;
      end
    end else begin
      if (clr) begin
        m_mode = 0; m_digits.delete(); m_ovf = 0;
      end else if (en) begin
        m_op = digits_value(0, 0); m_we = 1; m_mode = 2;
      end else if (is_digit) begin
        if (m_digits.size() < 3 && digits_value(d, 1) <= 255) m_digits.push_back(d);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic compare_model();
    check("operand_o", int'(operand_o), m_op);
    check("we_o", int'(we_o), int'(m_we));
    check("overflow_o", int'(overflow_o), int'(m_ovf));
    check("busy_o", int'(busy_o), (m_mode != 0) ? 1 : 0);
  endtask

  // One clock: drive, let the edge happen, advance the model, compare 1 time unit later.
  task automatic cycle(input bit rst, input int d, input bit dv, input bit en, input bit clr);
    reset_i = rst; digit_i = 4'(d); digit_valid_i = dv; enter_i = en; clear_i = clr;
    @(posedge clock_i);
    model_step(rst, d, dv, en, clr);
    #1;
    compare_model();
  endtask

  task automatic dig(input int d);
    cycle(0, d, 1, 0, 0);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic enter();
    cycle(0, 0, 0, 1, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0);
    check("reset operand", int'(operand_o), 0);
    check("reset busy", int'(busy_o), 0);
    cycle(1, 5, 1, 1, 1);
    idle();

    // 1,2,3 enter
    dig(1); dig(2); dig(3); enter();
    check("r31 we", int'(we_o), 1);
    check("r31 operand", int'(operand_o), 123);
    idle();
    check("r31 we drop", int'(we_o), 0);
    check("r31 busy drop", int'(busy_o), 0);

    // 2,5,6: 256 exceeds 8 bits
    dig(2); dig(5); dig(6);
    check("r32 overflow", int'(overflow_o), 1);
    enter();
    check("r32 operand", int'(operand_o), 25);
    idle();
    check("r32 overflow clr", int'(overflow_o), 0);

    // 2,5,5 is exactly the 8-bit ceiling
    dig(2); dig(5); dig(5); enter();
    check("max operand", int'(operand_o), 255);
    check("max no overflow", int'(overflow_o), 0);
    idle();

    // leading zeros count against the digit limit
    dig(0); dig(0); dig(1); dig(2);
    check("r33 overflow", int'(overflow_o), 1);
    enter();
    check("r33 operand", int'(operand_o), 1);
    idle();

    // clear discards, code 12 is inert
    dig(4); dig(7); cycle(0, 0, 0, 0, 1);
    check("r34 no we", int'(we_o), 0);
    check("r34 busy", int'(busy_o), 0);
    check("r34 operand held", int'(operand_o), 1);
    dig(12);
    check("r34 code12 idle", int'(busy_o), 0);
    dig(5); dig(12);
    check("r34 code12 ovf", int'(overflow_o), 0);
    enter();
    check("r34 operand", int'(operand_o), 5);
    idle();

    // digit with enter in IDLE: enter wins and is ignored
    cycle(0, 9, 1, 1, 0);
    check("r35 busy", int'(busy_o), 0);
    enter();
    check("r35 we", int'(we_o), 0);
    idle();

    // reset during the commit cycle
    dig(4); dig(2); enter();
    check("r36 we", int'(we_o), 1);
    cycle(1, 0, 0, 0, 0);
    check("r36 we", int'(we_o), 0);
    check("r36 operand", int'(operand_o), 0);
    idle();
    check("r36 no second", int'(we_o), 0);

    // clear during commit is ignored
    dig(8); enter(); cycle(0, 3, 1, 1, 1);
    check("commit ignores clear", int'(operand_o), 8);
    idle();

    for (int i = 0; i < 4000; i++) begin
      int r = $urandom_range(0, 99);
      int d = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      cycle(r < 1, d, $urandom_range(0, 1), r >= 1 && r < 9, r >= 9 && r < 13);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
